// File: rtl/inv_mixcol.sv
// AES InvMixColumns engine: reads one 128-bit state from SRAM, transforms it, writes it back.
// Build option INV_MIXCOL_PARALLEL_EN: transform all four columns in one COMPUTE cycle instead of one per cycle.
module inv_mixcol (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         invmix_enable,
  input  logic [127:0] sramReadValue,
  output logic [127:0] sramWriteValue,
  output logic         invmix_finished,
  output logic         sramRead,
  output logic         sramWrite,
  output logic         sramDump,
  output logic         sramInit,
  output logic [15:0]  sramAddr,
  output logic [2:0]   sramDumpNum,
  output logic [2:0]   sramInitNum
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, COMPUTE, WRITE, DONE} stateType;

  stateType    stateReg, stateNext;
  logic [31:0] bufCol [4];
  logic [3:0]  colUpdate;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // k selects which of b, 2b, 4b, 8b are summed; InvMixColumns only needs 09/0b/0d/0e.
  function automatic logic [7:0] gfMul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[3]}} & x8) ^ ({8{k[2]}} & x4) ^ ({8{k[1]}} & x2) ^ ({8{k[0]}} & b);
  endfunction

  function automatic logic [31:0] invMixColumn(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = col;
    return {gfMul(s0, 4'he) ^ gfMul(s1, 4'hb) ^ gfMul(s2, 4'hd) ^ gfMul(s3, 4'h9),
            gfMul(s0, 4'h9) ^ gfMul(s1, 4'he) ^ gfMul(s2, 4'hb) ^ gfMul(s3, 4'hd),
            gfMul(s0, 4'hd) ^ gfMul(s1, 4'h9) ^ gfMul(s2, 4'he) ^ gfMul(s3, 4'hb),
            gfMul(s0, 4'hb) ^ gfMul(s1, 4'hd) ^ gfMul(s2, 4'h9) ^ gfMul(s3, 4'he)};
  endfunction

`ifndef INV_MIXCOL_PARALLEL_EN
  logic [1:0] colCnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                   colCnt <= 2'd0;
    else if (stateReg == LATCH)   colCnt <= 2'd0;
    else if (stateReg == COMPUTE) colCnt <= colCnt + 2'd1;
  end
`endif

  // Each column lives in its own register so a serial build touches only the active one.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gCol
`ifdef INV_MIXCOL_PARALLEL_EN
      assign colUpdate[gi] = (stateReg == COMPUTE);
`else
      assign colUpdate[gi] = (stateReg == COMPUTE) && (colCnt == 2'(gi));
`endif
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                 bufCol[gi] <= 32'd0;
        else if (stateReg == LATCH) bufCol[gi] <= sramReadValue[127-32*gi -: 32];
        else if (colUpdate[gi])     bufCol[gi] <= invMixColumn(bufCol[gi]);
      end
    end
  endgenerate

  assign sramWriteValue = {bufCol[0], bufCol[1], bufCol[2], bufCol[3]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (invmix_enable) stateNext = READ;
      READ:    stateNext = LATCH;
      LATCH:   stateNext = COMPUTE;
`ifdef INV_MIXCOL_PARALLEL_EN
      COMPUTE: stateNext = WRITE;
`else
      COMPUTE: if (colCnt == 2'd3) stateNext = WRITE;
`endif
      WRITE:   stateNext = DONE;
      DONE:    if (!invmix_enable) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they line up with the state yet never glitch.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sramRead        <= 1'b0;
      sramWrite       <= 1'b0;
      invmix_finished <= 1'b0;
      sramAddr        <= 16'd0;
    end else begin
      sramRead        <= (stateNext == READ);
      sramWrite       <= (stateNext == WRITE);
      invmix_finished <= (stateNext == DONE);
      sramAddr        <= (stateNext == READ || stateNext == WRITE) ? 16'd32 : 16'd0;
    end
  end

  assign sramDump    = 1'b0;
  assign sramInit    = 1'b0;
  assign sramDumpNum = 3'd0;
  assign sramInitNum = 3'd0;

endmodule

// File: tb/tb_inv_mixcol.sv
// Self-checking bench for inv_mixcol: scoreboard of expected write data, cycle-exact strobe timing.
module tb_inv_mixcol;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         invmix_enable;
  logic [127:0] sramReadValue;
  logic [127:0] sramWriteValue;
  logic         invmix_finished, sramRead, sramWrite, sramDump, sramInit;
  logic [15:0]  sramAddr;
  logic [2:0]   sramDumpNum, sramInitNum;

  int checks = 0;
  int errors = 0;
  logic [127:0] scoreQ [$];

`ifdef INV_MIXCOL_PARALLEL_EN
  localparam int EXP_WR  = 4;
  localparam int EXP_FIN = 5;
  localparam int MID_RST = 3;
`else
  localparam int EXP_WR  = 7;
  localparam int EXP_FIN = 8;
  localparam int MID_RST = 4;
`endif

  inv_mixcol dut (
    .clk(clk), .n_rst(n_rst), .invmix_enable(invmix_enable),
    .sramReadValue(sramReadValue), .sramWriteValue(sramWriteValue),
    .invmix_finished(invmix_finished), .sramRead(sramRead), .sramWrite(sramWrite),
    .sramDump(sramDump), .sramInit(sramInit), .sramAddr(sramAddr),
    .sramDumpNum(sramDumpNum), .sramInitNum(sramInitNum)
  );

  always #5 clk = ~clk;

  // Reference model: generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] refInvMix(input logic [127:0] st);
    logic [7:0] coef [4];
    logic [7:0] s [4];
    logic [7:0] o;
    logic [127:0] res = '0;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) s[r] = st[127 - 32*c - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        o = 8'd0;
        for (int j = 0; j < 4; j++) o = o ^ refMul(coef[(j - r + 4) % 4], s[j]);
        res[127 - 32*c - 8*r -: 8] = o;
      end
    end
    return res;
  endfunction

  task automatic checkAllZero(input string name);
    checks++;
    if (sramRead !== 1'b0 || sramWrite !== 1'b0 || invmix_finished !== 1'b0 ||
        sramAddr !== 16'd0 || sramWriteValue !== 128'd0 || sramDump !== 1'b0 ||
        sramInit !== 1'b0 || sramDumpNum !== 3'd0 || sramInitNum !== 3'd0) begin
      errors++;
      $display("FAIL %s: rd=%b wr=%b fin=%b addr=%h wval=%h, required all zero",
               name, sramRead, sramWrite, invmix_finished, sramAddr, sramWriteValue);
    end
  endtask

  // One full operation: enable held for enCycles edges, read data valid only in the cycle after sramRead.
  task automatic runOp(input logic [127:0] rd, input logic [127:0] expd, input int enCycles, input string name);
    int readCnt = 0, writeCnt = 0, readCyc = 0, writeCyc = 0, firstFin = 0, finCnt = 0;
    int lastCyc, expFinCnt;
    logic badMisc = 1'b0;
    logic wasRead = 1'b0;
    logic [127:0] got;
    scoreQ.push_back(expd);
    sramReadValue = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    invmix_enable = 1'b1;
    lastCyc = ((enCycles > EXP_FIN) ? enCycles : EXP_FIN) + 3;
    expFinCnt = ((enCycles > EXP_FIN) ? enCycles : EXP_FIN) - EXP_FIN + 1;
    for (int cyc = 1; cyc <= lastCyc; cyc++) begin
      @(negedge clk);
      if (sramDump || sramInit || sramDumpNum != 3'd0 || sramInitNum != 3'd0) badMisc = 1'b1;
      if ((sramRead || sramWrite) ? (sramAddr !== 16'd32) : (sramAddr !== 16'd0)) badMisc = 1'b1;
      if (sramRead) begin readCnt++; readCyc = cyc; end
      if (sramWrite) begin
        writeCnt++;
        writeCyc = cyc;
        checks++;
        if (scoreQ.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_write: got %h, required no write", name, sramWriteValue);
        end else begin
          got = scoreQ.pop_front();
          if (sramWriteValue !== got) begin
            errors++;
            $display("FAIL %s write_data: got %h, required %h", name, sramWriteValue, got);
          end
        end
      end
      if (invmix_finished) begin
        finCnt++;
        if (firstFin == 0) firstFin = cyc;
      end
      sramReadValue = wasRead ? rd : {$urandom(), $urandom(), $urandom(), $urandom()};
      wasRead = sramRead;
      if (cyc == enCycles) invmix_enable = 1'b0;
    end
    checks++;
    if (readCnt != 1 || readCyc != 1) begin
      errors++;
      $display("FAIL %s read_strobe: count %0d cycle %0d, required count 1 cycle 1", name, readCnt, readCyc);
    end
    checks++;
    if (writeCnt != 1 || writeCyc != EXP_WR) begin
      errors++;
      $display("FAIL %s write_strobe: count %0d cycle %0d, required count 1 cycle %0d", name, writeCnt, writeCyc, EXP_WR);
    end
    checks++;
    if (firstFin != EXP_FIN || finCnt != expFinCnt) begin
      errors++;
      $display("FAIL %s finished: first %0d cycles %0d, required first %0d cycles %0d",
               name, firstFin, finCnt, EXP_FIN, expFinCnt);
    end
    checks++;
    if (badMisc) begin
      errors++;
      $display("FAIL %s addr_misc: unexpected sramAddr or nonzero tie-off outputs, required addr 32 only on strobes", name);
    end
    checks++;
    if (sramWriteValue !== expd) begin
      errors++;
      $display("FAIL %s held_value: got %h, required %h", name, sramWriteValue, expd);
    end
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("FAIL %s scoreboard: %0d entries left, required 0", name, scoreQ.size());
      scoreQ.delete();
    end
    $display("op %s rd=%h exp=%h wr_cyc=%0d fin_cyc=%0d", name, rd, expd, writeCyc, firstFin);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    invmix_enable = 1'b0;
    sramReadValue = '0;
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge clk);
    checkAllZero("reset_hold");
    n_rst = 1'b1;
    @(negedge clk);
    checkAllZero("reset_release");
    $display("op reset done");
  endtask

  task automatic test_vectors;
    runOp(128'h046681e5e0cb199a48f8d37a2806264c, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1, "fips");
    runOp({4{32'h8e4da1bc}}, {4{32'hdb135345}}, 1, "col_repeat");
    runOp({16{8'h01}}, {16{8'h01}}, 1, "all_ones");
    runOp(128'd0, 128'd0, 1, "all_zero");
  endtask

  task automatic test_reset_mid;
    logic [127:0] rd = 128'h046681e5e0cb199a48f8d37a2806264c;
    int writes = 0;
    sramReadValue = rd;
    @(negedge clk);
    invmix_enable = 1'b1;
    for (int cyc = 1; cyc < MID_RST; cyc++) @(negedge clk);
    n_rst = 1'b0;
    invmix_enable = 1'b0;
    #1;
    checkAllZero("mid_reset_immediate");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) n_rst = 1'b1;
      if (sramWrite) writes++;
    end
    checks++;
    if (writes != 0) begin
      errors++;
      $display("FAIL mid_reset_suppress: %0d writes, required 0", writes);
    end
    $display("op mid_reset writes=%0d", writes);
    runOp(rd, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1, "after_reset");
  endtask

  task automatic test_enable_held;
    runOp(128'h046681e5e0cb199a48f8d37a2806264c, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 20, "held20");
  endtask

  task automatic test_back_to_back;
    logic [127:0] a = {$urandom(), $urandom(), $urandom(), $urandom()};
    logic [127:0] b = {$urandom(), $urandom(), $urandom(), $urandom()};
    runOp(a, refInvMix(a), 1, "rand_a");
    runOp(b, refInvMix(b), 3, "rand_b");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_reset_mid();
    test_enable_held();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
